// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state type, port identifiers and latency limit for mem_port_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} arb_state_t;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;
    localparam int MEM_LAT_MAX = 15;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences single-ported memory accesses for the CPU and debug ports
// Ports: clk/rst (sync, active-high); cpu_* and dbg_* level request ports with
// registered rdata and a one-cycle ack; mem_* drive the memory, mem_rdata returns
// MEM_LAT cycles after mem_en; busy is high outside IDLE.
// Build option: MEM_ARB_RR_EN selects round-robin on ties, otherwise dbg has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    arb_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              pick_dbg;

`ifdef MEM_ARB_RR_EN
    logic last_q;
    // On a tie the port that was not granted last wins; reset value makes the CPU win the first tie.
    always_ff @(posedge clk) begin
        if (rst) last_q <= PORT_DBG;
        else if (state_q == IDLE && (cpu_req || dbg_req)) last_q <= pick_dbg;
    end
    assign pick_dbg = dbg_req && (!cpu_req || last_q == PORT_CPU);
`else
    assign pick_dbg = dbg_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: if (cpu_req || dbg_req) begin
                grant_d = pick_dbg ? PORT_DBG : PORT_CPU;
                we_d    = pick_dbg ? dbg_we : cpu_we;
                addr_d  = pick_dbg ? dbg_addr : cpu_addr;
                wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d   = 4'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // counter at 1 marks the cycle where mem_rdata is valid
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (!we_q && grant_q == PORT_CPU) cpu_rdata_d = mem_rdata;
                    if (!we_q && grant_q == PORT_DBG) dbg_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= PORT_DBG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign mem_en    = state_q == ACCESS;
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign cpu_ack   = state_q == DONE && grant_q == PORT_CPU;
    assign dbg_ack   = state_q == DONE && grant_q == PORT_DBG;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter at MEM_LAT 2, 1 and 5
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int checks = 0;
    int errors = 0;

    logic        cpu_req [3], cpu_we [3], dbg_req [3], dbg_we [3];
    logic [31:0] cpu_addr [3], cpu_wdata [3], cpu_rdata [3];
    logic [31:0] dbg_addr [3], dbg_wdata [3], dbg_rdata [3];
    logic        cpu_ack [3], dbg_ack [3], mem_en [3], mem_we [3], busy [3];
    logic [31:0] mem_addr [3], mem_wdata [3], mem_rdata [3];

    typedef struct {
        int          k;
        logic        port;
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t        sbq [$];
    exp_t        mon_e;
    logic [31:0] mon_rd;
    logic [31:0] mdl [3][256];
    logic [31:0] last_cpu [3], last_dbg [3];

    function automatic int lat(input int k);
        return k == 0 ? 2 : (k == 1 ? 1 : 5);
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a == 32'h40 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
        logic [31:0] mem [256];
        logic        wr [256];
        logic [31:0] pipe [16];
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
            .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
            .dbg_wdata(dbg_wdata[g]), .dbg_rdata(dbg_rdata[g]), .dbg_ack(dbg_ack[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
        always @(posedge clk) begin
            if (cyc == 0) for (int i = 0; i < 256; i++) wr[i] <= 1'b0;
            else if (mem_en[g] && mem_we[g]) begin
                mem[mem_addr[g][9:2]] <= mem_wdata[g];
                wr[mem_addr[g][9:2]]  <= 1'b1;
            end
            pipe[0] <= (mem_en[g] && !mem_we[g])
                ? (wr[mem_addr[g][9:2]] ? mem[mem_addr[g][9:2]] : init_word(mem_addr[g]))
                : 32'h0BADF00D;
            for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    always @(negedge clk) begin
        if (!rst) for (int k = 0; k < 3; k++) if (cpu_ack[k] || dbg_ack[k]) begin
            checks++;
            if (cpu_ack[k] && dbg_ack[k]) begin
                errors++;
                $display("FAIL both_acks inst %0d cycle %0d: cpu_ack=1 dbg_ack=1 required only one", k, cyc);
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack inst %0d cycle %0d: port=%0d acked, required no ack", k, cyc, dbg_ack[k]);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.k != k || mon_e.port != dbg_ack[k] || mon_e.cyc != cyc) begin
                    errors++;
                    $display("FAIL ack_grant: got inst %0d port %0d cycle %0d, required inst %0d port %0d cycle %0d",
                             k, dbg_ack[k], cyc, mon_e.k, mon_e.port, mon_e.cyc);
                end
                checks++;
                mon_rd = dbg_ack[k] ? dbg_rdata[k] : cpu_rdata[k];
                if (mon_rd !== mon_e.data) begin
                    errors++;
                    $display("FAIL ack_rdata inst %0d port %0d cycle %0d: rdata=%h required %h", k, dbg_ack[k], cyc, mon_rd, mon_e.data);
                end
            end
        end
    end

    task automatic issue(input int k, input logic p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input int dly);
        exp_t e;
        if (p == PORT_DBG) begin
            dbg_req[k] = 1'b1; dbg_we[k] = we; dbg_addr[k] = a; dbg_wdata[k] = d;
        end else begin
            cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d;
        end
        if (we) mdl[k][a[9:2]] = d;
        else if (p == PORT_DBG) last_dbg[k] = mdl[k][a[9:2]];
        else last_cpu[k] = mdl[k][a[9:2]];
        e.k    = k;
        e.port = p;
        e.cyc  = cyc + dly;
        e.data = (p == PORT_DBG) ? last_dbg[k] : last_cpu[k];
        sbq.push_back(e);
    endtask

    task automatic wait_ack(input int k, input logic p, input bit keep);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = (p == PORT_DBG) ? dbg_ack[k] : cpu_ack[k];
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout inst %0d port %0d: ack=0 required=1 within 40 cycles", k, p);
        end
        @(negedge clk);
        if (!keep) begin
            if (p == PORT_DBG) dbg_req[k] = 1'b0;
            else cpu_req[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cpu_req[k] = 1'b0; dbg_req[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        for (int k = 0; k < 3; k++) begin
            last_cpu[k] = '0; last_dbg[k] = '0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks += 5;
            if ({busy[k], cpu_ack[k], dbg_ack[k], mem_en[k], mem_we[k]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl inst %0d: busy/cpu_ack/dbg_ack/mem_en/mem_we=%b required 00000", k,
                         {busy[k], cpu_ack[k], dbg_ack[k], mem_en[k], mem_we[k]});
            end
            if (mem_addr[k] !== 32'h0) begin errors++; $display("FAIL reset_mem_addr inst %0d: %h required 0", k, mem_addr[k]); end
            if (mem_wdata[k] !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata inst %0d: %h required 0", k, mem_wdata[k]); end
            if (cpu_rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata inst %0d: %h required 0", k, cpu_rdata[k]); end
            if (dbg_rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_dbg_rdata inst %0d: %h required 0", k, dbg_rdata[k]); end
        end
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        issue(0, PORT_CPU, 1'b0, 32'h40, 32'h0, 4);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            checks += 3;
            if (mem_en[0] !== (c == 1)) begin errors++; $display("FAIL read_mem_en cycle %0d: %b required %b", c, mem_en[0], c == 1); end
            if (busy[0] !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL read_busy cycle %0d: %b required %b", c, busy[0], c >= 1 && c <= 4); end
            if (dbg_ack[0] !== 1'b0) begin errors++; $display("FAIL read_dbg_ack cycle %0d: %b required 0", c, dbg_ack[0]); end
            if (c == 4) begin
                checks++;
                if (cpu_ack[0] !== 1'b1 || cpu_rdata[0] !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL read_ack cycle 4: ack=%b rdata=%h required ack=1 rdata=deadbeef", cpu_ack[0], cpu_rdata[0]);
                end
            end
            if (c == 5) cpu_req[0] = 1'b0;
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        issue(0, PORT_CPU, 1'b1, 32'h80, 32'h12345678, 4);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if ({mem_en[0], mem_we[0]} !== {2{c == 1}}) begin
                errors++;
                $display("FAIL write_strobe cycle %0d: en/we=%b required %b", c, {mem_en[0], mem_we[0]}, {2{c == 1}});
            end
            if (c == 4) begin
                checks++;
                if (cpu_ack[0] !== 1'b1 || cpu_rdata[0] !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL write_ack cycle 4: ack=%b rdata=%h required ack=1 rdata=deadbeef", cpu_ack[0], cpu_rdata[0]);
                end
            end
            if (c == 5) issue(0, PORT_CPU, 1'b0, 32'h80, 32'h0, 4);
        end
        wait_ack(0, PORT_CPU, 1'b0);
        checks++;
        if (cpu_rdata[0] !== 32'h12345678) begin errors++; $display("FAIL write_readback: %h required 12345678", cpu_rdata[0]); end
    endtask

    task automatic test_addr_hold();
        @(negedge clk);
        issue(0, PORT_CPU, 1'b0, 32'h40, 32'h0, 4);
        @(negedge clk);
        @(negedge clk);
        cpu_addr[0] = 32'h44;
        @(negedge clk);
        checks++;
        if (mem_addr[0] !== 32'h40) begin errors++; $display("FAIL addr_hold: mem_addr=%h required 00000040", mem_addr[0]); end
        wait_ack(0, PORT_CPU, 1'b0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h80;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_reset_busy_before: %b required 1", busy[0]); end
        rst = 1'b1;
        cpu_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        last_cpu[0] = '0; last_dbg[0] = '0;
        checks += 2;
        if ({busy[0], cpu_ack[0], dbg_ack[0], mem_en[0]} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: busy/cpu_ack/dbg_ack/mem_en=%b required 0000", {busy[0], cpu_ack[0], dbg_ack[0], mem_en[0]});
        end
        if (mem_addr[0] !== 32'h0 || cpu_rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_data: mem_addr=%h cpu_rdata=%h required 0 0", mem_addr[0], cpu_rdata[0]);
        end
        repeat (6) @(negedge clk);
        issue(0, PORT_CPU, 1'b0, 32'h40, 32'h0, 4);
        wait_ack(0, PORT_CPU, 1'b0);
    endtask

    task automatic test_tie();
        logic win;
`ifdef MEM_ARB_RR_EN
        win = PORT_CPU;
`else
        win = PORT_DBG;
`endif
        do_reset();
        issue(0, win, 1'b0, win ? 32'h104 : 32'h100, 32'h0, 4);
        issue(0, !win, 1'b0, win ? 32'h100 : 32'h104, 32'h0, 9);
        wait_ack(0, win, 1'b0);
        wait_ack(0, !win, 1'b0);
        issue(0, PORT_CPU, 1'b0, 32'h108, 32'h0, 4);
        wait_ack(0, PORT_CPU, 1'b0);
        issue(0, PORT_DBG, 1'b0, 32'h114, 32'h0, 4);
        issue(0, PORT_CPU, 1'b0, 32'h110, 32'h0, 9);
        wait_ack(0, PORT_DBG, 1'b0);
        wait_ack(0, PORT_CPU, 1'b0);
        checks++;
        if (dbg_rdata[0] !== init_word(32'h114)) begin errors++; $display("FAIL tie_dbg_rdata: %h required %h", dbg_rdata[0], init_word(32'h114)); end
    endtask

    task automatic test_back_to_back(input int k);
        logic [31:0] v;
        v = 32'hC0DE_0000 | 32'(k);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            issue(k, PORT_CPU, 1'b0, 32'h200 + 32'(i * 4), 32'h0, lat(k) + 2);
            wait_ack(k, PORT_CPU, i < 2);
        end
        issue(k, PORT_DBG, 1'b1, 32'h20C, v, lat(k) + 2);
        wait_ack(k, PORT_DBG, 1'b1);
        issue(k, PORT_DBG, 1'b0, 32'h20C, 32'h0, lat(k) + 2);
        wait_ack(k, PORT_DBG, 1'b0);
        checks++;
        if (dbg_rdata[k] !== v) begin errors++; $display("FAIL b2b_dbg_readback inst %0d: %h required %h", k, dbg_rdata[k], v); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
            dbg_req[k] = 1'b0; dbg_we[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
            for (int i = 0; i < 256; i++) mdl[k][i] = init_word(32'(i * 4));
        end
        do_reset();
        test_reset();
        test_cpu_read();
        test_write_read();
        test_addr_hold();
        test_mid_reset();
        test_tie();
        test_back_to_back(1);
        test_back_to_back(2);
        repeat (10) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d pending acks, required 0", sbq.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single-ported unified instruction/data memory of the multicycle CPU. It shares the memory between the CPU port (fetch, lw, sw accesses selected by the control FSM) and a debug/loader port. It issues each access with a fixed memory latency and returns a one-cycle acknowledge to the winning requester. The CPU control FSM stalls on a missing ack.

## Interface
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15; elaboration error otherwise.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  last CPU read data, registered.
- cpu_ack  out  1  one-cycle completion pulse.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port, same rules as CPU.
- dbg_rdata  out  DATA_W  and dbg_ack  out  1  debug port, same rules as CPU.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, valid with mem_en.
- mem_addr  out  ADDR_W  and mem_wdata  out  DATA_W  registered, held from ACCESS through DONE.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: when any req is high, pick a winner. Register its we/addr/wdata into mem_*, record the grant, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: mem_en=1 and mem_we=granted we for exactly one cycle. Load the latency counter with MEM_LAT. Go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter equals 1, mem_rdata is valid: capture it into the granted port's rdata register on reads only, then go to DONE.
- DONE: assert the granted port's ack for one cycle. The other port's ack stays 0. Return to IDLE.
- Writes follow identical timing. The rdata registers are untouched by writes and hold their value until the next read completion for that port.
- Handshake: the requester drops req, or presents a new access, in the cycle after ack. A req still high in IDLE after its ack is a new access.
- Fields sampled only on the IDLE→ACCESS edge. Changes to req/we/addr/wdata during an access are ignored.
- A req that drops before grant is simply never served. No ack is issued.
- Fixed priority (see Configuration for the macro case): dbg wins when both ports request in the same IDLE cycle.

## Timing
- Request seen in IDLE cycle t. mem_en in cycle t+1. mem_rdata valid in cycle t+1+MEM_LAT. ack and rdata valid in cycle t+2+MEM_LAT. Next IDLE in cycle t+3+MEM_LAT.
- Minimum spacing between accesses: MEM_LAT+3 cycles, including one IDLE bubble.
- Reset values: state IDLE, busy 0, both acks 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0, dbg_rdata 0, last-grant = dbg.
- rst mid-access: next cycle is IDLE with all outputs at reset values. No ack is issued. A write already strobed may have completed in memory; the requester must re-issue.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on simultaneous requests. The port not granted last wins. last-grant updates on every grant; after reset the CPU wins the first tie.
- Not defined: fixed priority, dbg over cpu. The last-grant register is not built.
- Single-requester behaviour is identical in both builds.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT, DONE);
  - port-id constants PORT_CPU=0 and PORT_DBG=1;
  - the MEM_LAT legal-range limit constant.
- No sub-module. The latency counter, the grant logic and the FSM stay in one module.

## Test plan
- CPU read alone, MEM_LAT=2, addr 0x40, memory word 0xDEADBEEF, req at cycle 0:
  - mem_en high only in cycle 1;
  - cpu_ack and cpu_rdata=0xDEADBEEF in cycle 4;
  - dbg_ack never asserts.
- CPU write 0x12345678 to 0x80: mem_we=1 with mem_en in cycle 1 and cpu_ack in cycle 4. A following read of 0x80 returns 0x12345678; cpu_rdata is unchanged between the two accesses.
- Both reqs high in the same IDLE cycle, both held until their acks:
  - Macro off: dbg is acked first, then cpu 5 cycles later.
  - Macro on (after reset): cpu first, then dbg. A second tie goes to the opposite port from the previous winner.
- cpu_addr changed from 0x40 to 0x44 during WAIT: mem_addr stays 0x40 and the data returned is from 0x40.
- rst asserted in a WAIT cycle: the next cycle is IDLE with busy=0 and no ack ever issued. A fresh cpu read then completes with normal latency.
- MEM_LAT=1 and MEM_LAT=5 sweeps: ack lands exactly MEM_LAT+2 cycles after the req cycle. Back-to-back CPU reads are spaced MEM_LAT+3 cycles apart.
